// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage access controller: funct3 codes,
// FSM state encoding, store lane packing and load extension helpers.
package mem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam int unsigned XLEN = 32;
   localparam int unsigned BE_W = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2,
      S_ERR  = 2'd3
   } state_t;

   // Store payload as presented on the bus
   typedef struct packed {
      logic [XLEN-1:0] wdata;
      logic [BE_W-1:0] be;
   } lane_t;

   // Replicate the store datum across lanes and enable the addressed bytes
   function automatic lane_t store_lanes(input logic [XLEN-1:0] wd,
                                         input logic [1:0]      off,
                                         input logic [2:0]      f3);
      lane_t l;
      l.wdata = wd;
      l.be    = 4'b1111;
      case (f3)
         F3_B: begin
            l.wdata = {4{wd[7:0]}};
            l.be    = 4'b0001 << off;
         end
         F3_H: begin
            l.wdata = {2{wd[15:0]}};
            l.be    = off[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            l.wdata = wd;
            l.be    = 4'b1111;
         end
      endcase
      return l;
   endfunction

   // Pick the addressed byte/half out of the read word and extend it
   function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] rdata,
                                                   input logic [1:0]      off,
                                                   input logic [2:0]      f3);
      logic [XLEN-1:0] sh_b;
      logic [XLEN-1:0] sh_h;
      logic [7:0]      b;
      logic [15:0]     h;
      sh_b = rdata >> {off, 3'b000};
      sh_h = off[1] ? {16'h0000, rdata[31:16]} : rdata;
      b    = sh_b[7:0];
      h    = sh_h[15:0];
      case (f3)
         F3_B:    return {{24{b[7]}}, b};
         F3_H:    return {{16{h[15]}}, h};
         F3_BU:   return {24'h000000, b};
         F3_HU:   return {16'h0000, h};
         default: return rdata;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data-bus req/ack interface between the MEM-stage controller (master)
// and the memory slave.
//   bus_req   : request, held until ack
//   bus_we    : 1 = write
//   bus_addr  : word-aligned address
//   bus_wdata : lane-replicated store data
//   bus_be    : byte enables
//   bus_rdata : read word, valid with bus_ack
//   bus_ack   : single-cycle completion
interface mem_access_ctrl_if;
   import mem_pkg::*;

   logic            bus_req;
   logic            bus_we;
   logic [XLEN-1:0] bus_addr;
   logic [XLEN-1:0] bus_wdata;
   logic [BE_W-1:0] bus_be;
   logic [XLEN-1:0] bus_rdata;
   logic            bus_ack;

   modport master (
      output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
      input  bus_rdata, bus_ack
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
      output bus_rdata, bus_ack
   );

endinterface

// File: rtl/mem_access_ctrl_load_align.sv
// Combinational load formatter: selects the addressed byte/half of the
// read word and sign/zero extends according to funct3.
//   rdata  : raw bus read word
//   offset : addr[1:0] of the load
//   funct3 : load size/sign
//   data   : formatted load result
module load_align
   import mem_pkg::*;
(
   input  logic [XLEN-1:0] rdata,
   input  logic [1:0]      offset,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] data
);

   always_comb begin
      data = load_extend(rdata, offset, funct3);
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage access sequencer: issues one req/ack bus transaction per
// load/store, stalls the upstream pipeline until it completes, formats
// load data and flags misaligned, illegal and timed-out accesses.
//   clk, rst             : clock, synchronous active-high reset
//   mem_write_m/read_m   : store / load in MEM (both set = store)
//   funct3_m, addr_m     : access size/sign and byte address
//   wdata_m              : store data
//   bus                  : data-bus master port
//   stall                : combinational hold for IF/ID/EX and EX/MEM
//   load_data/load_valid : formatted load result and its one-cycle strobe
//   misaligned(_addr)    : alignment fault pulse and held faulting address
//   illegal_op           : reserved-funct3 pulse
//   bus_err              : sticky timeout flag
module mem_access_ctrl
   import mem_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mem_write_m,
   input  logic                 mem_read_m,
   input  logic [2:0]           funct3_m,
   input  logic [XLEN-1:0]      addr_m,
   input  logic [XLEN-1:0]      wdata_m,
   mem_access_ctrl_if.master    bus,
   output logic                 stall,
   output logic [XLEN-1:0]      load_data,
   output logic                 load_valid,
   output logic                 misaligned,
   output logic [XLEN-1:0]      misaligned_addr,
   output logic                 illegal_op,
   output logic                 bus_err
);

   localparam int unsigned CNT_RAW = $clog2(TIMEOUT + 1);
   localparam int unsigned CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q;
   logic [2:0]         f3_q;
   logic [1:0]         off_q;

   logic               access;
   logic               legal;
   logic               aligned;
   logic               timeout_hit;
   logic               start, fault_mis, fault_ill, ack_take, to_err;
   lane_t              lanes;
   logic [XLEN-1:0]    load_fmt;

   // Decode the access sitting in EX/MEM
   always_comb begin
      access  = mem_write_m | mem_read_m;
      if (mem_write_m)
         legal = (funct3_m == F3_B) || (funct3_m == F3_H) || (funct3_m == F3_W);
      else
         legal = (funct3_m == F3_B) || (funct3_m == F3_H) || (funct3_m == F3_W) ||
                 (funct3_m == F3_BU) || (funct3_m == F3_HU);
      case (funct3_m)
         F3_H, F3_HU: aligned = ~addr_m[0];
         F3_W:        aligned = (addr_m[1:0] == 2'b00);
         default:     aligned = 1'b1;
      endcase
      lanes = store_lanes(wdata_m, addr_m[1:0], funct3_m);
   end

   // Timeout disabled entirely when TIMEOUT is 0
   always_comb begin
      timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
   end

   load_align u_load_align (
      .rdata  (bus.bus_rdata),
      .offset (off_q),
      .funct3 (f3_q),
      .data   (load_fmt)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next state, stall and per-cycle action strobes
   always_comb begin
      state_d   = state_q;
      stall     = 1'b0;
      start     = 1'b0;
      fault_mis = 1'b0;
      fault_ill = 1'b0;
      ack_take  = 1'b0;
      to_err    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (access) begin
               if (!legal) begin
                  fault_ill = 1'b1;
               end else if (!aligned) begin
                  fault_mis = 1'b1;
               end else begin
                  stall   = 1'b1;
                  start   = 1'b1;
                  state_d = S_BUSY;
               end
            end
         end
         S_BUSY: begin
            stall = 1'b1;
            // An ack arriving on the timeout cycle still completes the access
            if (bus.bus_ack) begin
               ack_take = 1'b1;
               state_d  = S_DONE;
            end else if (timeout_hit) begin
               to_err  = 1'b1;
               state_d = S_ERR;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         S_ERR: begin
            stall = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Registered bus outputs, fault pulses and load result
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.bus_req     <= 1'b0;
         bus.bus_we      <= 1'b0;
         bus.bus_addr    <= '0;
         bus.bus_wdata   <= '0;
         bus.bus_be      <= '0;
         load_data       <= '0;
         load_valid      <= 1'b0;
         misaligned      <= 1'b0;
         misaligned_addr <= '0;
         illegal_op      <= 1'b0;
         bus_err         <= 1'b0;
         cnt_q           <= '0;
         f3_q            <= '0;
         off_q           <= '0;
      end else begin
         load_valid <= 1'b0;
         misaligned <= 1'b0;
         illegal_op <= 1'b0;

         if (start) begin
            bus.bus_req  <= 1'b1;
            bus.bus_we   <= mem_write_m;
            bus.bus_addr <= {addr_m[31:2], 2'b00};
            // Reads drive all byte enables and no write data
            if (mem_write_m) begin
               bus.bus_wdata <= lanes.wdata;
               bus.bus_be    <= lanes.be;
            end else begin
               bus.bus_wdata <= '0;
               bus.bus_be    <= 4'b1111;
            end
            f3_q  <= funct3_m;
            off_q <= addr_m[1:0];
            cnt_q <= '0;
         end

         if (fault_ill) illegal_op <= 1'b1;

         if (fault_mis) begin
            misaligned      <= 1'b1;
            misaligned_addr <= addr_m;
         end

         if (state_q == S_BUSY) cnt_q <= cnt_q + CNT_W'(1);

         if (ack_take) begin
            bus.bus_req <= 1'b0;
            if (!bus.bus_we) begin
               load_data  <= load_fmt;
               load_valid <= 1'b1;
            end
         end

         if (to_err) begin
            bus.bus_req <= 1'b0;
            bus_err     <= 1'b1;
         end
      end
   end

endmodule
